// File: rtl/lfsr_prpg_misr.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_prpg_misr
// Description : Polynomial-programmable Fibonacci LFSR engine for BIST.
//               PRPG mode emits a bounded burst of pseudo-random patterns.
//               MISR mode compacts response words into a signature.
//               Includes a start/busy/done sequencer, step counting and
//               all-zero lock-up detection with reseed recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prpg_misr #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] POLY         = 32'h8020_0003,
    parameter logic [WIDTH-1:0] INITIAL_SEED = 32'hDEAD_BEEF,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_steps,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data,
    input  logic [WIDTH-1:0] misr_in,
    input  logic             misr_valid,
    output logic [WIDTH-1:0] pattern_out,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic             lockup_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic              MODE_PRPG = 1'b0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   signature_q, signature_d;
    logic               lockup_q, lockup_d;

    logic               fb;
    logic [WIDTH-1:0]   shifted;
    logic               step_en;

    // Feedback tap and shifted value are shared by both modes.
    always_comb begin
        fb      = ^(lfsr_q & POLY);
        shifted = {lfsr_q[WIDTH-2:0], fb};
        step_en = (mode_q == MODE_PRPG) ? 1'b1 : misr_valid;
    end

    // Sequencer next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        mode_d      = mode_q;
        signature_d = signature_q;
        lockup_d    = lockup_q;

        unique case (state_q)
            S_IDLE: begin
                // Seed load takes effect first so a same-cycle start uses it.
                if (seed_load) begin
                    lfsr_d = seed_data;
                end
                if (start) begin
                    mode_d = mode;
                    num_d  = num_steps;
                    cnt_d  = '0;
                    if (num_steps != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d     = S_DONE;
                        signature_d = lfsr_d;
                    end
                end
            end
            S_RUN: begin
                if (step_en) begin
                    if (mode_q != MODE_PRPG) begin
                        lfsr_d = shifted ^ misr_in;
                    end else if (lfsr_q == '0) begin
                        // All-zero PRPG state would never leave zero: reseed.
                        lfsr_d   = INITIAL_SEED;
                        lockup_d = 1'b1;
                    end else begin
                        lfsr_d = shifted;
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == (num_q - CNT_ONE)) begin
                        state_d     = S_DONE;
                        signature_d = lfsr_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= INITIAL_SEED;
            cnt_q       <= '0;
            num_q       <= '0;
            mode_q      <= MODE_PRPG;
            signature_q <= '0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            mode_q      <= mode_d;
            signature_q <= signature_d;
            lockup_q    <= lockup_d;
        end
    end

    assign pattern_out   = lfsr_q;
    assign pattern_valid = (state_q == S_RUN) && (mode_q == MODE_PRPG);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign signature     = signature_q;
    assign lockup_err    = lockup_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prpg_misr.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_prpg_misr
// Description : Directed self-checking bench for lfsr_prpg_misr.
//               Inputs change and outputs are sampled on the falling edge.
//               Expected LFSR values are hand-derived from the default tap
//               mask 0x80200003 (fb = s[31]^s[21]^s[1]^s[0]).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_prpg_misr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] num_steps;
    logic        seed_load;
    logic [31:0] seed_data;
    logic [31:0] misr_in;
    logic        misr_valid;
    logic [31:0] pattern_out;
    logic        pattern_valid;
    logic        busy;
    logic        done;
    logic [31:0] signature;
    logic        lockup_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_prpg_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .num_steps    (num_steps),
        .seed_load    (seed_load),
        .seed_data    (seed_data),
        .misr_in      (misr_in),
        .misr_valid   (misr_valid),
        .pattern_out  (pattern_out),
        .pattern_valid(pattern_valid),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .lockup_err   (lockup_err)
    );

    // Safety net: the run is a fixed number of cycles, never open-ended.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; num_steps = '0;
        seed_load = 1'b0; seed_data = '0; misr_in = '0; misr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_reg: got %h want %h", pattern_out, 32'hDEADBEEF); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (pattern_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %b want 0", pattern_valid); end
        n_cmp++; if (signature !== 32'h0) begin n_fail++; $display("FAIL reset_sig: got %h want 0", signature); end
        n_cmp++; if (lockup_err !== 1'b0) begin n_fail++; $display("FAIL reset_lockup: got %b want 0", lockup_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_prpg_default();
        logic [31:0] exp_pat [3];
        int busy_cycles;
        exp_pat = '{32'hDEADBEEF, 32'hBD5B7DDE, 32'h7AB6FBBC};
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; num_steps = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            n_cmp++; if (pattern_out !== exp_pat[i]) begin n_fail++; $display("FAIL prpg_pat%0d: got %h want %h", i, pattern_out, exp_pat[i]); end
            n_cmp++; if (pattern_valid !== 1'b1) begin n_fail++; $display("FAIL prpg_pvalid%0d: got %b want 1", i, pattern_valid); end
        end
        @(negedge clk);
        if (busy) busy_cycles++;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL prpg_done: got %b want 1", done); end
        n_cmp++; if (signature !== 32'hF56DF779) begin n_fail++; $display("FAIL prpg_sig: got %h want %h", signature, 32'hF56DF779); end
        n_cmp++; if (pattern_valid !== 1'b0) begin n_fail++; $display("FAIL prpg_pvalid_done: got %b want 0", pattern_valid); end
        @(negedge clk);
        if (busy) busy_cycles++;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL prpg_done_pulse: got %b want 0", done); end
        n_cmp++; if (busy_cycles != 3) begin n_fail++; $display("FAIL prpg_busy_len: got %0d want 3", busy_cycles); end
    endtask

    task automatic test_seed_load();
        logic [31:0] exp_pat [4];
        exp_pat = '{32'h00000001, 32'h00000003, 32'h00000006, 32'h0000000D};
        seed_load = 1'b1; seed_data = 32'h00000001;
        @(negedge clk);
        seed_load = 1'b0;
        n_cmp++; if (pattern_out !== 32'h00000001) begin n_fail++; $display("FAIL seed_loaded: got %h want 00000001", pattern_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seed_no_run: got %b want 0", busy); end
        start = 1'b1; mode = 1'b0; num_steps = 16'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if (pattern_out !== exp_pat[i]) begin n_fail++; $display("FAIL seed_pat%0d: got %h want %h", i, pattern_out, exp_pat[i]); end
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL seed_done: got %b want 1", done); end
        n_cmp++; if (signature !== 32'h0000001B) begin n_fail++; $display("FAIL seed_sig: got %h want 0000001B", signature); end
        @(negedge clk);
    endtask

    task automatic test_lockup();
        seed_load = 1'b1; seed_data = 32'h0;
        @(negedge clk);
        seed_load = 1'b0;
        start = 1'b1; mode = 1'b0; num_steps = 16'd2;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (pattern_out !== 32'h0) begin n_fail++; $display("FAIL lock_pat0: got %h want 00000000", pattern_out); end
        n_cmp++; if (lockup_err !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0", lockup_err); end
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lock_pat1: got %h want DEADBEEF", pattern_out); end
        n_cmp++; if (lockup_err !== 1'b1) begin n_fail++; $display("FAIL lock_set: got %b want 1", lockup_err); end
        n_cmp++; if (pattern_valid !== 1'b1) begin n_fail++; $display("FAIL lock_pvalid: got %b want 1", pattern_valid); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL lock_done: got %b want 1", done); end
        n_cmp++; if (signature !== 32'hBD5B7DDE) begin n_fail++; $display("FAIL lock_sig: got %h want BD5B7DDE", signature); end
        @(negedge clk);
        n_cmp++; if (lockup_err !== 1'b1) begin n_fail++; $display("FAIL lock_sticky: got %b want 1", lockup_err); end
    endtask

    task automatic test_misr();
        do_reset();
        n_cmp++; if (lockup_err !== 1'b0) begin n_fail++; $display("FAIL misr_lock_cleared: got %b want 0", lockup_err); end
        seed_load = 1'b1; seed_data = 32'h0;
        @(negedge clk);
        seed_load = 1'b0;
        start = 1'b1; mode = 1'b1; num_steps = 16'd2;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (pattern_valid !== 1'b0) begin n_fail++; $display("FAIL misr_pvalid: got %b want 0", pattern_valid); end
        misr_valid = 1'b1; misr_in = 32'h12345678;
        @(negedge clk);
        misr_valid = 1'b0; misr_in = 32'hA5A5A5A5;
        n_cmp++; if (pattern_out !== 32'h12345678) begin n_fail++; $display("FAIL misr_word0: got %h want 12345678", pattern_out); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b1 || pattern_out !== 32'h12345678) begin n_fail++; $display("FAIL misr_gap%0d: busy %b reg %h want 1 12345678", i, busy, pattern_out); end
        end
        misr_valid = 1'b1; misr_in = 32'h0000FFFF;
        @(negedge clk);
        misr_valid = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL misr_done: got %b want 1", done); end
        n_cmp++; if (signature !== 32'h2468530E) begin n_fail++; $display("FAIL misr_sig: got %h want 2468530E", signature); end
        n_cmp++; if (lockup_err !== 1'b0) begin n_fail++; $display("FAIL misr_lockup: got %b want 0", lockup_err); end
        @(negedge clk);
    endtask

    task automatic test_zero_steps();
        int busy_seen;
        busy_seen = 0;
        start = 1'b1; mode = 1'b0; num_steps = 16'd0;
        @(negedge clk);
        start = 1'b0;
        if (busy) busy_seen++;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        n_cmp++; if (signature !== 32'h2468530E) begin n_fail++; $display("FAIL zero_sig: got %h want 2468530E", signature); end
        @(negedge clk);
        if (busy) busy_seen++;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b want 0", done); end
        n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_back_to_back();
        // Seed load and start together: the run begins from the new seed.
        seed_load = 1'b1; seed_data = 32'h00000001;
        start = 1'b1; mode = 1'b0; num_steps = 16'd5;
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'h00000001) begin n_fail++; $display("FAIL b2b_pat0: got %h want 00000001", pattern_out); end
        // Requests during RUN must be ignored.
        seed_data = 32'hFFFFFFFF; mode = 1'b1; num_steps = 16'd1;
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'h00000003) begin n_fail++; $display("FAIL b2b_pat1: got %h want 00000003", pattern_out); end
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'h00000006 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_pat2: reg %h busy %b want 00000006 1", pattern_out, busy); end
        seed_load = 1'b0; start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (pattern_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_mid_reg: got %h want DEADBEEF", pattern_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_cmp++; if (signature !== 32'h0) begin n_fail++; $display("FAIL rst_mid_sig: got %h want 0", signature); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || pattern_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rst_mid_idle: done %b busy %b reg %h want 0 0 DEADBEEF", done, busy, pattern_out); end
    endtask

    initial begin
        test_reset();
        test_prpg_default();
        test_seed_load();
        test_lockup();
        test_misr();
        test_zero_steps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
